fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-granular arbiter sharing the async FIFO write port.
// Optional: define FIFO_WR_ARB_STALL_CNT_EN to add the stall_cnt/stall_clr full-stall counter.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    full,
    output logic                    wenable,
    output logic [DW-1:0]           wdata,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    input  logic                    stall_clr,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int unsigned   IW        = $clog2(NREQ);
    localparam int unsigned   BW        = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [IW-1:0] last_owner, last_owner_nxt;
    logic [BW-1:0] beat_cnt, beat_cnt_nxt;
    logic [IW-1:0] rr_winner, rr_pos;
    logic          rr_found;
    logic          own_valid, own_last;

    // Rotating priority: search starts at the requester just after the previous owner.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_pos    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            rr_pos = IW'((32'(last_owner) + i) % NREQ);
            if (!rr_found && req_valid[rr_pos]) begin
                rr_found  = 1'b1;
                rr_winner = rr_pos;
            end
        end
    end

    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];
    assign busy      = (state == BURST);
    assign grant_id  = owner;
    assign wdata     = req_data[owner*DW +: DW];

    // Reset gates the write strobe combinationally so a mid-burst reset never writes.
    assign wenable   = wrst_n && busy && own_valid && !full;
    assign req_ready = wenable ? (NREQ'(1) << owner) : '0;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NREQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    owner_nxt    = rr_winner;
                    beat_cnt_nxt = '0;
                    state_nxt    = BURST;
                end
            end
            BURST: begin
                if (!own_valid) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner;
                end else if (wenable) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (own_last || (beat_cnt == BEAT_LAST)) begin
                        state_nxt      = IDLE;
                        last_owner_nxt = owner;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    always_ff @(posedge wclk) begin
        if (!wrst_n || stall_clr) begin
            stall_cnt <= '0;
        end else if (busy && own_valid && full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
